// File: rtl/writeback_stage_if.sv
// MEM/WB payload type plus the writeback-stage port bundle.
// master = memory-stage / data-memory side, slave = writeback_stage.
package writeback_pkg;
    localparam int WB_PHYS_REG_BITS = 6;
    localparam logic [6:0] OP_LOAD = 7'b0000011;

    typedef struct packed {
        logic                        valid;
        logic [31:0]                 pc;
        logic [6:0]                  opcode;
        logic [2:0]                  funct3;
        logic [4:0]                  dest_arch;
        logic [WB_PHYS_REG_BITS-1:0] dest_phys_new;
        logic [WB_PHYS_REG_BITS-1:0] dest_phys_old;
        logic                        regf_we;
        logic [1:0]                  regfilemux_sel;
        logic [31:0]                 alu_out;
        logic                        br_en;
        logic [31:0]                 u_imm;
        logic [31:0]                 dmem_addr;
        logic [3:0]                  dmem_rmask;
        logic [3:0]                  dmem_wmask;
    } mem_wb_stage_reg_t;
endpackage

interface writeback_stage_if;
    import writeback_pkg::*;

    mem_wb_stage_reg_t             mem_wb;
    logic [31:0]                   dmem_rdata;
    logic                          dmem_resp;
    mem_wb_stage_reg_t             mem_wb_now;
    logic                          freeze_stall;
    logic                          rd_we;
    logic [WB_PHYS_REG_BITS-1:0]   rd_phys;
    logic [31:0]                   rd_v;
    logic                          commit_valid;
    logic [WB_PHYS_REG_BITS-1:0]   free_phys;
    logic                          free_valid;
    logic [63:0]                   commit_order;
    logic                          dmem_timeout;

    modport master (
        output mem_wb, dmem_rdata, dmem_resp,
        input  mem_wb_now, freeze_stall, rd_we, rd_phys, rd_v, commit_valid,
               free_phys, free_valid, commit_order, dmem_timeout
    );

    modport slave (
        input  mem_wb, dmem_rdata, dmem_resp,
        output mem_wb_now, freeze_stall, rd_we, rd_phys, rd_v, commit_valid,
               free_phys, free_valid, commit_order, dmem_timeout
    );
endinterface

// File: rtl/writeback_stage.sv
// RV32I writeback stage: holds MEM/WB, freezes on outstanding dmem access, retires.
// Optional DMEM_TIMEOUT_EN builds a sticky watchdog on dmem_timeout.
//
// state | meaning
// IDLE  | no data-memory request outstanding for mem_wb_now
// WAIT  | mem_wb_now is a memop whose dmem response has not arrived
module writeback_stage
    import writeback_pkg::*;
#(
    parameter int PHYS_REG_BITS  = WB_PHYS_REG_BITS,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic              clk,
    input logic              rst,
    writeback_stage_if.slave wb
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state, state_next;
    mem_wb_stage_reg_t mem_wb_q;
    logic [63:0]       commit_count;
    logic              freeze, commit, write_rd;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       load_v, reg_v, rd_v_c;

    function automatic logic is_memop(mem_wb_stage_reg_t p);
        return p.valid && ((p.dmem_rmask | p.dmem_wmask) != 4'b0000);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            mem_wb_q     <= '0;
            commit_count <= '0;
        end else begin
            state <= state_next;
            if (!freeze) begin
                mem_wb_q <= wb.mem_wb;
            end
            if (commit) begin
                commit_count <= commit_count + 64'd1;
            end
        end
    end

    // The response cycle already accepts the next payload, so back-to-back memops stay in WAIT.
    always_comb begin
        state_next = state;
        if (!freeze) begin
            state_next = is_memop(wb.mem_wb) ? WAIT : IDLE;
        end
    end

    always_comb begin
        freeze   = (state == WAIT) && !wb.dmem_resp;
        commit   = mem_wb_q.valid && !freeze;
        write_rd = commit && mem_wb_q.regf_we && (mem_wb_q.dest_arch != 5'd0);
    end

    // Load data is consumed straight off the bus in the response cycle; nothing is latched.
    always_comb begin
        ld_byte = wb.dmem_rdata[{mem_wb_q.dmem_addr[1:0], 3'b000} +: 8];
        ld_half = wb.dmem_rdata[{mem_wb_q.dmem_addr[1], 4'b0000} +: 16];
        case (mem_wb_q.funct3)
            3'b000:  load_v = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_v = {24'h000000, ld_byte};
            3'b001:  load_v = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_v = {16'h0000, ld_half};
            default: load_v = wb.dmem_rdata;
        endcase
        case (mem_wb_q.regfilemux_sel)
            2'd0:    reg_v = mem_wb_q.alu_out;
            2'd1:    reg_v = {31'd0, mem_wb_q.br_en};
            2'd2:    reg_v = mem_wb_q.u_imm;
            default: reg_v = mem_wb_q.pc + 32'd4;
        endcase
        rd_v_c = (mem_wb_q.opcode == OP_LOAD) ? load_v : reg_v;
    end

    assign wb.mem_wb_now   = mem_wb_q;
    assign wb.freeze_stall = freeze;
    assign wb.rd_we        = write_rd;
    assign wb.rd_phys      = mem_wb_q.dest_phys_new[PHYS_REG_BITS-1:0];
    assign wb.rd_v         = rd_v_c;
    assign wb.commit_valid = commit;
    assign wb.free_phys    = mem_wb_q.dest_phys_old[PHYS_REG_BITS-1:0];
    assign wb.free_valid   = write_rd;
    assign wb.commit_order = commit_count;

`ifdef DMEM_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

    logic [31:0] wait_count;
    logic        timeout_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_count <= '0;
            timeout_q  <= 1'b0;
        end else if (!freeze && state_next == WAIT) begin
            wait_count <= '0;
        end else if (freeze) begin
            wait_count <= wait_count + 32'd1;
            if (wait_count + 32'd1 == TIMEOUT_LIMIT) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign wb.dmem_timeout = timeout_q;
`else
    // Watchdog not built; the limit parameter is kept so both builds share one interface.
    if (TIMEOUT_CYCLES >= 0) begin : g_no_watchdog
        assign wb.dmem_timeout = 1'b0;
    end
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: scoreboard of expected commits,
// one task per scenario, inputs driven just after posedge and sampled at negedge.
module tb_writeback_stage;
    import writeback_pkg::*;

    localparam int TIMEOUT = 8;
`ifdef DMEM_TIMEOUT_EN
    localparam bit WATCHDOG_BUILT = 1'b1;
`else
    localparam bit WATCHDOG_BUILT = 1'b0;
`endif

    typedef struct packed {
        logic        we;
        logic [5:0]  phys_new;
        logic [5:0]  phys_old;
        logic [31:0] v;
        logic [63:0] order;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [63:0] exp_order = '0;
    exp_t        sb[$];

    writeback_stage_if wb_if();

    writeback_stage #(
        .PHYS_REG_BITS (6),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb (wb_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "tb_writeback_stage stopped by time limit");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic mem_wb_stage_reg_t mk_alu(input logic [4:0] arch, input logic [5:0] pn,
                                                 input logic [5:0] po, input logic [1:0] sel,
                                                 input logic [31:0] alu, input logic br,
                                                 input logic [31:0] uimm, input logic [31:0] pc);
        mem_wb_stage_reg_t p;
        p                = '0;
        p.valid          = 1'b1;
        p.pc             = pc;
        p.opcode         = 7'b0110011;
        p.dest_arch      = arch;
        p.dest_phys_new  = pn;
        p.dest_phys_old  = po;
        p.regf_we        = 1'b1;
        p.regfilemux_sel = sel;
        p.alu_out        = alu;
        p.br_en          = br;
        p.u_imm          = uimm;
        return p;
    endfunction

    function automatic mem_wb_stage_reg_t mk_load(input logic [2:0] f3, input logic [4:0] arch,
                                                  input logic [5:0] pn, input logic [5:0] po,
                                                  input logic [31:0] addr, input logic [3:0] rmask);
        mem_wb_stage_reg_t p;
        p               = '0;
        p.valid         = 1'b1;
        p.pc            = 32'h0000_0200;
        p.opcode        = 7'b0000011;
        p.funct3        = f3;
        p.dest_arch     = arch;
        p.dest_phys_new = pn;
        p.dest_phys_old = po;
        p.regf_we       = 1'b1;
        p.alu_out       = addr;
        p.dmem_addr     = addr;
        p.dmem_rmask    = rmask;
        return p;
    endfunction

    function automatic mem_wb_stage_reg_t mk_store(input logic [31:0] addr);
        mem_wb_stage_reg_t p;
        p            = '0;
        p.valid      = 1'b1;
        p.pc         = 32'h0000_0300;
        p.opcode     = 7'b0100011;
        p.funct3     = 3'b010;
        p.alu_out    = 32'h0BAD_0BAD;
        p.dmem_addr  = addr;
        p.dmem_wmask = 4'b1111;
        return p;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return d;
        endcase
    endfunction

    task automatic push_exp(input mem_wb_stage_reg_t p, input logic [31:0] v);
        exp_t e;
        e.we       = p.regf_we && (p.dest_arch != 5'd0);
        e.phys_new = p.dest_phys_new;
        e.phys_old = p.dest_phys_old;
        e.v        = v;
        e.order    = exp_order;
        sb.push_back(e);
        exp_order++;
    endtask

    task automatic test_reset();
        rst              = 1'b0;
        wb_if.mem_wb     = mk_alu(5'd3, 6'd9, 6'd1, 2'd0, 32'hFFFF_FFFF, 1'b1, 32'h1, 32'h100);
        wb_if.dmem_resp  = 1'b1;
        wb_if.dmem_rdata = '1;
        cyc();
        cyc();
        @(negedge clk);
        tests_run++;
        if ({wb_if.mem_wb_now, wb_if.freeze_stall, wb_if.rd_we, wb_if.rd_phys, wb_if.rd_v,
             wb_if.commit_valid, wb_if.free_phys, wb_if.free_valid, wb_if.commit_order,
             wb_if.dmem_timeout} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b freeze=%b rd_we=%b rd_v=%h commit=%b order=%0d, required all zero",
                     wb_if.mem_wb_now.valid, wb_if.freeze_stall, wb_if.rd_we, wb_if.rd_v,
                     wb_if.commit_valid, wb_if.commit_order);
        end
        cyc();
        rst              = 1'b1;
        wb_if.mem_wb     = '0;
        wb_if.dmem_resp  = 1'b0;
        wb_if.dmem_rdata = '0;
        cyc();
        @(negedge clk);
        tests_run++;
        if ({wb_if.commit_valid, wb_if.freeze_stall, wb_if.commit_order} !== '0) begin
            tests_failed++;
            $display("FAIL reset_release: commit=%b freeze=%b order=%0d, required 0 0 0",
                     wb_if.commit_valid, wb_if.freeze_stall, wb_if.commit_order);
        end
        cyc();
    endtask

    task automatic test_alu();
        mem_wb_stage_reg_t ins [5];
        logic [31:0]       vals [5];
        exp_t              e;
        ins[0] = mk_alu(5'd5, 6'd10, 6'd20, 2'd0, 32'h0000_1234, 1'b0, 32'h0, 32'h40);
        vals[0] = 32'h0000_1234;
        ins[1] = mk_alu(5'd6, 6'd11, 6'd21, 2'd1, 32'hDEAD_0000, 1'b1, 32'h0, 32'h44);
        vals[1] = 32'h0000_0001;
        ins[2] = mk_alu(5'd7, 6'd12, 6'd22, 2'd2, 32'h0, 1'b1, 32'hABCD_E000, 32'h48);
        vals[2] = 32'hABCD_E000;
        ins[3] = mk_alu(5'd9, 6'd13, 6'd23, 2'd3, 32'h55, 1'b0, 32'h0, 32'h0000_104C);
        vals[3] = 32'h0000_1050;
        ins[4] = mk_alu(5'd0, 6'd14, 6'd24, 2'd0, 32'h77, 1'b0, 32'h0, 32'h50);
        vals[4] = 32'h0000_0077;
        wb_if.mem_wb = ins[0];
        push_exp(ins[0], vals[0]);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            if (i < 5) begin
                wb_if.mem_wb = ins[i];
                push_exp(ins[i], vals[i]);
            end else begin
                wb_if.mem_wb = '0;
            end
            @(negedge clk);
            tests_run++;
            if (sb.size() == 0 || wb_if.commit_valid !== 1'b1 || wb_if.freeze_stall !== 1'b0) begin
                tests_failed++;
                $display("FAIL alu_commit[%0d]: commit=%b freeze=%b queued=%0d, required commit=1 freeze=0",
                         i - 1, wb_if.commit_valid, wb_if.freeze_stall, sb.size());
            end else begin
                e = sb.pop_front();
                tests_run++;
                if ({wb_if.rd_we, wb_if.free_valid, wb_if.commit_order} !== {e.we, e.we, e.order} ||
                    (e.we && {wb_if.rd_phys, wb_if.free_phys, wb_if.rd_v} !== {e.phys_new, e.phys_old, e.v})) begin
                    tests_failed++;
                    $display("FAIL alu_data[%0d]: we=%b free=%b order=%0d phys=%0d old=%0d v=%h, required we=%b order=%0d phys=%0d old=%0d v=%h",
                             i - 1, wb_if.rd_we, wb_if.free_valid, wb_if.commit_order, wb_if.rd_phys,
                             wb_if.free_phys, wb_if.rd_v, e.we, e.order, e.phys_new, e.phys_old, e.v);
                end
            end
        end
        cyc();
        @(negedge clk);
        tests_run++;
        if (wb_if.commit_valid !== 1'b0 || wb_if.commit_order !== exp_order) begin
            tests_failed++;
            $display("FAIL alu_idle: commit=%b order=%0d, required commit=0 order=%0d",
                     wb_if.commit_valid, wb_if.commit_order, exp_order);
        end
        cyc();
    endtask

    task automatic test_load_byte();
        exp_t e;
        wb_if.mem_wb = mk_load(3'b000, 5'd7, 6'd11, 6'd21, 32'h0000_1003, 4'b1000);
        push_exp(wb_if.mem_wb, 32'hFFFF_FF80);
        cyc();
        wb_if.mem_wb = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if ({wb_if.freeze_stall, wb_if.commit_valid} !== 2'b10) begin
                tests_failed++;
                $display("FAIL lb_wait[%0d]: freeze=%b commit=%b, required freeze=1 commit=0",
                         i, wb_if.freeze_stall, wb_if.commit_valid);
            end
            cyc();
        end
        wb_if.dmem_resp  = 1'b1;
        wb_if.dmem_rdata = 32'h80FF_FFFF;
        @(negedge clk);
        tests_run++;
        if (sb.size() == 0 || wb_if.commit_valid !== 1'b1 || wb_if.freeze_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL lb_commit: commit=%b freeze=%b, required commit=1 freeze=0",
                     wb_if.commit_valid, wb_if.freeze_stall);
        end else begin
            e = sb.pop_front();
            tests_run++;
            if ({wb_if.rd_we, wb_if.free_valid, wb_if.commit_order} !== {e.we, e.we, e.order} ||
                {wb_if.rd_phys, wb_if.free_phys, wb_if.rd_v} !== {e.phys_new, e.phys_old, e.v}) begin
                tests_failed++;
                $display("FAIL lb_data: we=%b free=%b order=%0d phys=%0d v=%h, required we=%b order=%0d phys=%0d v=%h",
                         wb_if.rd_we, wb_if.free_valid, wb_if.commit_order, wb_if.rd_phys, wb_if.rd_v,
                         e.we, e.order, e.phys_new, e.v);
            end
        end
        cyc();
        wb_if.dmem_resp  = 1'b0;
        wb_if.dmem_rdata = '0;
        @(negedge clk);
        tests_run++;
        if ({wb_if.commit_valid, wb_if.freeze_stall} !== 2'b00) begin
            tests_failed++;
            $display("FAIL lb_once: commit=%b freeze=%b, required 0 0",
                     wb_if.commit_valid, wb_if.freeze_stall);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        mem_wb_stage_reg_t st;
        exp_t              e;
        wb_if.mem_wb = mk_load(3'b101, 5'd8, 6'd12, 6'd22, 32'h0000_2002, 4'b1100);
        push_exp(wb_if.mem_wb, 32'h0000_BEEF);
        cyc();
        st               = mk_store(32'h0000_2010);
        wb_if.mem_wb     = st;
        push_exp(st, 32'h0);
        wb_if.dmem_resp  = 1'b1;
        wb_if.dmem_rdata = 32'hBEEF_0000;
        @(negedge clk);
        tests_run++;
        if (sb.size() == 0 || wb_if.commit_valid !== 1'b1 || wb_if.freeze_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL lhu_commit: commit=%b freeze=%b, required commit=1 freeze=0",
                     wb_if.commit_valid, wb_if.freeze_stall);
        end else begin
            e = sb.pop_front();
            tests_run++;
            if ({wb_if.rd_we, wb_if.free_valid, wb_if.commit_order} !== {e.we, e.we, e.order} ||
                {wb_if.rd_phys, wb_if.free_phys, wb_if.rd_v} !== {e.phys_new, e.phys_old, e.v}) begin
                tests_failed++;
                $display("FAIL lhu_data: we=%b free=%b order=%0d phys=%0d v=%h, required we=%b order=%0d phys=%0d v=%h",
                         wb_if.rd_we, wb_if.free_valid, wb_if.commit_order, wb_if.rd_phys, wb_if.rd_v,
                         e.we, e.order, e.phys_new, e.v);
            end
        end
        cyc();
        wb_if.dmem_resp  = 1'b0;
        wb_if.dmem_rdata = '0;
        wb_if.mem_wb     = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if ({wb_if.freeze_stall, wb_if.commit_valid} !== 2'b10) begin
                tests_failed++;
                $display("FAIL sw_wait[%0d]: freeze=%b commit=%b, required freeze=1 commit=0",
                         i, wb_if.freeze_stall, wb_if.commit_valid);
            end
            cyc();
        end
        wb_if.dmem_resp = 1'b1;
        @(negedge clk);
        tests_run++;
        if (sb.size() == 0 || wb_if.commit_valid !== 1'b1 || wb_if.freeze_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL sw_commit: commit=%b freeze=%b, required commit=1 freeze=0",
                     wb_if.commit_valid, wb_if.freeze_stall);
        end else begin
            e = sb.pop_front();
            tests_run++;
            if ({wb_if.rd_we, wb_if.free_valid, wb_if.commit_order} !== {e.we, e.we, e.order}) begin
                tests_failed++;
                $display("FAIL sw_data: we=%b free=%b order=%0d, required we=%b free=%b order=%0d",
                         wb_if.rd_we, wb_if.free_valid, wb_if.commit_order, e.we, e.we, e.order);
            end
        end
        cyc();
        wb_if.dmem_resp = 1'b0;
    endtask

    task automatic test_load_align();
        logic [2:0]        f3s [5];
        logic [31:0]       data [20];
        mem_wb_stage_reg_t p;
        exp_t              e;
        f3s[0] = 3'b000;
        f3s[1] = 3'b100;
        f3s[2] = 3'b001;
        f3s[3] = 3'b101;
        f3s[4] = 3'b010;
        for (int i = 0; i < 20; i++) data[i] = $urandom;
        p = mk_load(f3s[0], 5'd1, 6'd32, 6'd0, 32'h0000_3000, 4'hF);
        wb_if.mem_wb = p;
        push_exp(p, ref_load(f3s[0], 2'd0, data[0]));
        for (int i = 1; i <= 20; i++) begin
            cyc();
            wb_if.dmem_resp  = 1'b1;
            wb_if.dmem_rdata = data[i-1];
            if (i < 20) begin
                p = mk_load(f3s[i/4], 5'(1 + i), 6'(32 + i), 6'(i),
                            32'h0000_3000 + 32'(i * 4 + i % 4), 4'hF);
                wb_if.mem_wb = p;
                push_exp(p, ref_load(f3s[i/4], 2'(i % 4), data[i]));
            end else begin
                wb_if.mem_wb = '0;
            end
            @(negedge clk);
            tests_run++;
            if (sb.size() == 0 || wb_if.commit_valid !== 1'b1 || wb_if.freeze_stall !== 1'b0) begin
                tests_failed++;
                $display("FAIL ld_align_commit[%0d]: commit=%b freeze=%b, required commit=1 freeze=0",
                         i - 1, wb_if.commit_valid, wb_if.freeze_stall);
            end else begin
                e = sb.pop_front();
                tests_run++;
                if ({wb_if.rd_we, wb_if.commit_order, wb_if.rd_phys, wb_if.rd_v} !==
                    {e.we, e.order, e.phys_new, e.v}) begin
                    tests_failed++;
                    $display("FAIL ld_align[%0d]: we=%b order=%0d phys=%0d v=%h, required we=%b order=%0d phys=%0d v=%h",
                             i - 1, wb_if.rd_we, wb_if.commit_order, wb_if.rd_phys, wb_if.rd_v,
                             e.we, e.order, e.phys_new, e.v);
                end
            end
        end
        cyc();
        wb_if.dmem_resp  = 1'b0;
        wb_if.dmem_rdata = '0;
    endtask

    task automatic test_x0_load();
        exp_t e;
        wb_if.mem_wb = mk_load(3'b010, 5'd0, 6'd15, 6'd25, 32'h0000_6000, 4'hF);
        push_exp(wb_if.mem_wb, 32'hDEAD_BEEF);
        cyc();
        wb_if.mem_wb     = '0;
        wb_if.dmem_resp  = 1'b1;
        wb_if.dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        tests_run++;
        if (sb.size() == 0 || wb_if.commit_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL x0_commit: commit=%b, required 1", wb_if.commit_valid);
        end else begin
            e = sb.pop_front();
            tests_run++;
            if ({wb_if.rd_we, wb_if.free_valid, wb_if.commit_order} !== {1'b0, 1'b0, e.order}) begin
                tests_failed++;
                $display("FAIL x0_data: we=%b free=%b order=%0d, required we=0 free=0 order=%0d",
                         wb_if.rd_we, wb_if.free_valid, wb_if.commit_order, e.order);
            end
        end
        cyc();
        wb_if.dmem_resp  = 1'b0;
        wb_if.dmem_rdata = '0;
        @(negedge clk);
        tests_run++;
        if (wb_if.commit_order !== exp_order) begin
            tests_failed++;
            $display("FAIL x0_order: order=%0d, required %0d", wb_if.commit_order, exp_order);
        end
        cyc();
    endtask

    task automatic test_spurious_resp();
        wb_if.mem_wb     = '0;
        wb_if.dmem_resp  = 1'b1;
        wb_if.dmem_rdata = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            cyc();
            @(negedge clk);
            tests_run++;
            if ({wb_if.freeze_stall, wb_if.commit_valid, wb_if.rd_we} !== 3'b000) begin
                tests_failed++;
                $display("FAIL spurious_resp[%0d]: freeze=%b commit=%b we=%b, required 0 0 0",
                         i, wb_if.freeze_stall, wb_if.commit_valid, wb_if.rd_we);
            end
        end
        cyc();
        wb_if.dmem_resp  = 1'b0;
        wb_if.dmem_rdata = '0;
    endtask

    task automatic test_reset_mid_wait();
        wb_if.mem_wb = mk_load(3'b010, 5'd9, 6'd14, 6'd24, 32'h0000_4000, 4'hF);
        cyc();
        wb_if.mem_wb = '0;
        @(negedge clk);
        tests_run++;
        if (wb_if.freeze_stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_wait_entry: freeze=%b, required 1", wb_if.freeze_stall);
        end
        rst = 1'b0;
        cyc();
        rst              = 1'b1;
        wb_if.dmem_resp  = 1'b1;
        wb_if.dmem_rdata = 32'hCAFE_F00D;
        exp_order        = '0;
        sb.delete();
        @(negedge clk);
        tests_run++;
        if ({wb_if.commit_valid, wb_if.freeze_stall, wb_if.rd_we, wb_if.commit_order} !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_wait: commit=%b freeze=%b we=%b order=%0d, required all 0",
                     wb_if.commit_valid, wb_if.freeze_stall, wb_if.rd_we, wb_if.commit_order);
        end
        cyc();
        wb_if.dmem_resp  = 1'b0;
        wb_if.dmem_rdata = '0;
        @(negedge clk);
        tests_run++;
        if ({wb_if.commit_valid, wb_if.freeze_stall} !== 2'b00) begin
            tests_failed++;
            $display("FAIL rst_late_resp: commit=%b freeze=%b, required 0 0",
                     wb_if.commit_valid, wb_if.freeze_stall);
        end
        cyc();
    endtask

    task automatic test_timeout();
        logic exp_to;
        wb_if.mem_wb = mk_load(3'b010, 5'd4, 6'd30, 6'd31, 32'h0000_5000, 4'hF);
        cyc();
        wb_if.mem_wb = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            exp_to = WATCHDOG_BUILT && (k >= TIMEOUT);
            tests_run++;
            if ({wb_if.freeze_stall, wb_if.dmem_timeout} !== {1'b1, exp_to}) begin
                tests_failed++;
                $display("FAIL timeout[%0d]: freeze=%b timeout=%b, required freeze=1 timeout=%b",
                         k, wb_if.freeze_stall, wb_if.dmem_timeout, exp_to);
            end
            cyc();
        end
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({wb_if.freeze_stall, wb_if.dmem_timeout} !== 2'b00) begin
            tests_failed++;
            $display("FAIL timeout_reset: freeze=%b timeout=%b, required 0 0",
                     wb_if.freeze_stall, wb_if.dmem_timeout);
        end
        cyc();
    endtask

    initial begin
        wb_if.mem_wb     = '0;
        wb_if.dmem_resp  = 1'b0;
        wb_if.dmem_rdata = '0;
        test_reset();
        test_alu();
        test_load_byte();
        test_back_to_back();
        test_load_align();
        test_x0_load();
        test_spurious_resp();
        test_reset_mid_wait();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final stage of the in-order RV32I pipeline, directly downstream of the memory stage.
- Registers the MEM/WB payload (mem_wb_stage_reg_t) and tracks the outstanding data-memory request issued in MEM.
- Generates freeze_stall while that request is pending, then aligns and extends load data.
- Drives the physical register-file write port, retires instructions, and returns the old physical destination to the rename free list.

Parameters:
- PHYS_REG_BITS, 6, width of physical register tags.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-low (0 = reset).
- mem_wb  in  struct  mem_wb_stage_reg_t produced by the memory stage this cycle.
- dmem_rdata  in  32  read data, word-aligned, valid when dmem_resp=1.
- dmem_resp  in  1  data-memory response pulse.
- mem_wb_now  out  struct  registered MEM/WB payload. Fed back to the memory stage for request replay.
- freeze_stall  out  1  whole-pipeline hold.
- rd_we  out  1  physical register-file write enable.
- rd_phys  out  PHYS_REG_BITS  write tag, equal to mem_wb_now.dest_phys_new.
- rd_v  out  32  write data.
- commit_valid  out  1  one-cycle retire pulse.
- free_phys  out  PHYS_REG_BITS  tag to release, equal to mem_wb_now.dest_phys_old.
- free_valid  out  1  free_phys valid.
- commit_order  out  64  retire count before this commit.
- dmem_timeout  out  1  watchdog error (optional feature only, else tied 0).

Behaviour:
- Reset (rst=0 at posedge):
  - mem_wb_now is all-zero with valid=0.
  - state=IDLE, commit_order=0.
  - All outputs are 0 the following cycle.
- State machine:
  - States: IDLE, WAIT. Define memop = valid and (dmem_rmask or dmem_wmask) nonzero.
  - At posedge with freeze_stall=0: mem_wb_now <= mem_wb; state <= WAIT if mem_wb is memop, else IDLE.
  - At posedge with freeze_stall=1: mem_wb_now and state hold.
- freeze_stall = (state==WAIT) and not dmem_resp. This is combinational.
  - The response cycle unfreezes the pipeline in the same cycle.
  - In that same cycle the memory stage issues the next request from mem_wb.
  - Back-to-back memory ops therefore stay in WAIT with no bubble.
- dmem_resp while in IDLE (stale or spurious) is ignored.
- Commit condition: commit_valid = mem_wb_now.valid and not freeze_stall. It is combinational.
  - Each instruction commits exactly once.
  - A non-memop commits in its first cycle in WB.
- rd_we = commit_valid and regf_we and (dest_arch != 0).
- free_valid = rd_we. Stores, branches and x0 destinations free nothing.
- commit_order increments by 1 at each posedge where commit_valid=1.
- rd_v selection:
  - Loads (opcode op_load): rd_v is aligned/extended dmem_rdata, with off = dmem_addr[1:0].
    - lb: sign-extended byte at [8*off +: 8].
    - lbu: zero-extended byte at [8*off +: 8].
    - lh: sign-extended half at [16*off[1] +: 16].
    - lhu: zero-extended half at [16*off[1] +: 16].
    - lw: full word.
  - Non-loads: rd_v follows regfilemux_sel among alu_out, zero-extended br_en, u_imm, and pc+4.
- Load data path: dmem_rdata is used combinationally in the dmem_resp cycle and is not latched. rd_v is don't-care when rd_we=0.
- Reset mid-WAIT: state returns to IDLE and no commit occurs. A late dmem_resp is ignored.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entry to WAIT and increments each cycle in WAIT without dmem_resp.
  - When the counter reaches TIMEOUT_CYCLES, dmem_timeout asserts and stays set until reset.
  - The pipeline stays frozen.
- Undefined: no counter is built and dmem_timeout is tied to 0.

Test Plan:
- ALU op to x5, then a bubble: mem_wb valid, regf_we=1, alu_out=0x1234 -> next cycle rd_we=1, rd_v=0x1234, commit_valid=1, commit_order=0, freeze_stall=0.
- lb, dmem_addr=0x1003, rmask=1000, resp delayed 3 cycles, dmem_rdata=0x80FFFFFF:
  - freeze_stall=1 for 3 cycles.
  - In the response cycle: rd_v=0xFFFFFF80, rd_we=1, single commit.
- lhu at addr 0x2002 with immediate resp, data 0xBEEF0000 -> rd_v=0x0000BEEF. The following sw has wmask=1111 and resp 2 cycles later -> state stays WAIT, no bubble between commits, store gives rd_we=0 and free_valid=0.
- Load to x0 (dest_arch=0), resp with data 0xDEADBEEF -> commit_valid=1, rd_we=0, free_valid=0, commit_order increments.
- rst=0 during WAIT, then dmem_resp=1 with rst=1 -> no commit, freeze_stall=0, state IDLE, commit_order=0.
- DMEM_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no resp -> dmem_timeout=1 after 8 WAIT cycles, stays set until reset.
